// File: rtl/ahb_lite_sram_slave_p.sv
// ahb_lite_sram_slave_p: AHB-Lite SRAM slave with configurable wait states, byte lanes and two-cycle ERROR.
// Define AHB_SLV_PROT_EN to reject non-privileged accesses to the upper half of memory.
module ahb_lite_sram_slave_p #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);
  localparam int NB = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * NB);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
  state_t state, next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic [LSB-1:0] off;
  logic [2:0] size;
  logic wr;
  logic [3:0] cnt;
  logic accept, bad, prot_err;
  logic [NB-1:0] lane;
  logic unused;
  assign unused = ^{htrans[0], hburst, hprot};
`ifdef AHB_SLV_PROT_EN
  assign prot_err = !hprot[1] && haddr[LSB+IW-1];
`else
  assign prot_err = 1'b0;
`endif
  assign bad = int'(hsize) > LSB
            || (haddr & ((ADDR_W'(1) << hsize) - ADDR_W'(1))) != '0
            || {1'b0, haddr} >= MEM_BYTES
            || prot_err;
  assign accept = hsel && hready && htrans[1] && hreadyout;
  always_comb begin
    hreadyout = !(state == WAIT || state == ERR1);
    hresp = state == ERR1 || state == ERR2;
    next = !accept ? IDLE : bad ? ERR1 : WAIT_STATES > 0 ? WAIT : DATA;
    if (state == WAIT) next = cnt == '0 ? DATA : WAIT;
    if (state == ERR1) next = ERR2;
  end
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      off <= '0;
      size <= '0;
      wr <= 1'b0;
    end else begin
      state <= next;
      cnt <= accept ? WS_INIT : state == WAIT ? cnt - 4'd1 : cnt;
      if (accept) begin
        idx <= haddr[LSB +: IW];
        off <= haddr[LSB-1:0];
        size <= hsize;
        wr <= hwrite;
      end
    end
  // little-endian lanes covering 2^size bytes starting at the byte offset
  always_comb begin
    lane = '0;
    for (int b = 0; b < NB; b++) lane[b] = b >= int'(off) && b < int'(off) + (1 << size);
  end
  always_ff @(posedge hclk)
    if (state == DATA && wr)
      for (int b = 0; b < NB; b++)
        if (lane[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
  assign hrdata = state == DATA && !wr ? mem[idx] : '0;
endmodule

// File: tb/tb_ahb_lite_sram_slave_p.sv
// tb_ahb_lite_sram_slave_p: pipelined AHB master against a byte-addressed memory model, on a zero-wait and a two-wait-state slave.
module tb_ahb_lite_sram_slave_p;
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  prot;
  } xfer_t;

  logic hclk = 1'b0;
  logic hreset;
  logic hsel_bus;
  logic [31:0] haddr;
  logic [1:0] htrans;
  logic hwrite;
  logic [2:0] hsize, hburst;
  logic [3:0] hprot;
  logic [31:0] hwdata;
  logic ho0, ho1, hr0, hr1;
  logic [31:0] rd0, rd1;
  logic rdy, rsp;
  logic [31:0] rd;
  int cur = 0;
  int errors = 0, checks = 0;
  int n_err_resp = 0;
  logic [31:0] last_rd;
  logic last_resp;
  xfer_t q[$];
  logic [7:0] mm [2][1024];
  bit kn [2][1024];

  always #5 hclk = ~hclk;

  ahb_lite_sram_slave_p u0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && cur == 0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(ho0), .hreadyout(ho0), .hresp(hr0), .hrdata(rd0)
  );

  ahb_lite_sram_slave_p #(.WAIT_STATES(2)) u1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_bus && cur == 1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(ho1), .hreadyout(ho1), .hresp(hr1), .hrdata(rd1)
  );

  assign rdy = cur == 1 ? ho1 : ho0;
  assign rsp = cur == 1 ? hr1 : hr0;
  assign rd  = cur == 1 ? rd1 : rd0;

  function automatic bit exp_err(input xfer_t t);
    bit e;
    e = t.size > 3'd2 || t.addr % (32'd1 << t.size) != 0 || t.addr >= 32'd1024;
`ifdef AHB_SLV_PROT_EN
    e = e || (!t.prot[1] && t.addr >= 32'd512 && t.addr < 32'd1024);
`endif
    return e;
  endfunction

  function automatic void push(input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [31:0] d, input logic [3:0] p);
    xfer_t t;
    t.addr = a; t.wr = w; t.size = s; t.wdata = d; t.prot = p;
    q.push_back(t);
  endfunction

  task automatic idle_bus();
    hsel_bus = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd0; hprot = 4'b0011; hburst = 3'd0;
  endtask

  task automatic present(input int idle_pct, output bit v, output xfer_t t);
    t = '0;
    v = q.size() > 0 && $urandom_range(99) >= idle_pct;
    if (v) t = q.pop_front();
    hsel_bus = v || $urandom_range(1) == 1;
    htrans = v ? 2'b10 + 2'($urandom_range(1)) : 2'($urandom_range(1));
    haddr = v ? t.addr : $urandom;
    hwrite = v ? t.wr : 1'($urandom_range(1));
    hsize = v ? t.size : 3'($urandom_range(7));
    hprot = v ? t.prot : 4'($urandom);
    hburst = 3'($urandom);
  endtask

  // drains q through the selected slave, checking every cycle against the model
  task automatic run(input int idle_pct, output int cyc);
    xfer_t bus_t, dp;
    bit bus_v, dp_v, rdy_prev, rsp_bad, e, mis;
    int lows, ws, wa;
    logic [31:0] expd;
    ws = cur == 1 ? 2 : 0;
    cyc = 0; dp_v = 0; lows = 0; rsp_bad = 0; dp = '0;
    rdy_prev = rdy;
    present(idle_pct, bus_v, bus_t);
    while (bus_v || dp_v || q.size() > 0) begin
      @(posedge hclk); #1;
      cyc++;
      if (rdy_prev) begin
        dp_v = bus_v; dp = bus_t; lows = 0; rsp_bad = 0;
        if (bus_v) hwdata = bus_t.wr ? bus_t.wdata : $urandom;
        present(idle_pct, bus_v, bus_t);
      end
      e = dp_v && exp_err(dp);
      if (dp_v && !rdy) begin
        lows++;
        rsp_bad = rsp_bad || rsp !== e;
        if (lows > 40) begin
          checks++; errors++;
          $display("FAIL stall addr=%h: hreadyout low %0d cycles, required %0d", dp.addr, lows, e ? 1 : ws);
          q.delete();
          break;
        end
      end else if (dp_v) begin
        checks++;
        if (lows != (e ? 1 : ws) || rsp !== e || rsp_bad) begin
          errors++;
          $display("FAIL phase addr=%h wr=%0d size=%0d: low=%0d hresp=%0d midbad=%0d, required low=%0d hresp=%0d",
                   dp.addr, dp.wr, dp.size, lows, rsp, rsp_bad, e ? 1 : ws, e);
        end
        last_resp = rsp;
        if (rsp === 1'b1) n_err_resp++;
        if (!e && dp.wr) begin
          for (int b = 0; b < (1 << dp.size); b++) begin
            wa = int'(dp.addr) + b;
            mm[cur][wa] = dp.wdata[8*(wa%4) +: 8];
            kn[cur][wa] = 1;
          end
        end else if (!e) begin
          wa = int'(dp.addr) & ~3;
          mis = 0; expd = '0;
          for (int b = 0; b < 4; b++) begin
            if (kn[cur][wa+b]) expd[8*b +: 8] = mm[cur][wa+b];
            if (kn[cur][wa+b] && rd[8*b +: 8] !== mm[cur][wa+b]) mis = 1;
          end
          checks++;
          if (mis) begin
            errors++;
            $display("FAIL rdata addr=%h: got %h, required %h (known bytes)", dp.addr, rd, expd);
          end
          last_rd = rd;
        end
        dp_v = 0;
      end else begin
        checks++;
        if (rdy !== 1'b1 || rsp !== 1'b0 || rd !== '0) begin
          errors++;
          $display("FAIL idle: hreadyout=%0d hresp=%0d hrdata=%h, required 1 0 0", rdy, rsp, rd);
        end
      end
      rdy_prev = rdy;
      if (cyc > 20000) begin
        checks++; errors++;
        $display("FAIL run_bound: %0d cycles, required completion", cyc);
        q.delete();
        break;
      end
    end
    idle_bus();
  endtask

  task automatic test_reset();
    hreset = 1'b1; idle_bus(); hwdata = '0;
    repeat (2) @(posedge hclk);
    #1;
    checks++;
    if (ho0 !== 1'b1 || hr0 !== 1'b0 || rd0 !== '0) begin
      errors++; $display("FAIL reset0: %0d %0d %h, required 1 0 0", ho0, hr0, rd0);
    end
    checks++;
    if (ho1 !== 1'b1 || hr1 !== 1'b0 || rd1 !== '0) begin
      errors++; $display("FAIL reset1: %0d %0d %h, required 1 0 0", ho1, hr1, rd1);
    end
    @(negedge hclk) hreset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    cur = 0;
    push(32'h10, 1, 3'd2, 32'hDEADBEEF, 4'b0011);
    push(32'h10, 0, 3'd2, 32'h0, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_rd !== 32'hDEADBEEF || last_resp !== 1'b0) begin
      errors++; $display("FAIL basic: got %h resp %0d, required deadbeef 0", last_rd, last_resp);
    end
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL basic_cycles: got %0d, required 2", cyc); end
  endtask

  task automatic test_byte_lane();
    int cyc;
    cur = 0;
    push(32'h10, 1, 3'd2, 32'h11223344, 4'b0011);
    push(32'h13, 1, 3'd0, 32'hAA000000, 4'b0011);
    push(32'h10, 0, 3'd2, 32'h0, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_rd !== 32'hAA223344) begin errors++; $display("FAIL byte_lane: got %h, required aa223344", last_rd); end
  endtask

  task automatic test_error();
    int cyc, n0;
    cur = 0;
    n0 = n_err_resp;
    push(32'h12, 1, 3'd2, 32'hFFFFFFFF, 4'b0011);
    push(32'h10, 0, 3'd2, 32'h0, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_rd !== 32'hAA223344 || n_err_resp - n0 != 1) begin
      errors++; $display("FAIL misaligned: got %h errs %0d, required aa223344 1", last_rd, n_err_resp - n0);
    end
    push(32'h0, 1, 3'd2, 32'hCAFEF00D, 4'b0011);
    run(0, cyc);
    n0 = n_err_resp;
    push(32'h400, 0, 3'd2, 32'h0, 4'b0011);
    push(32'h0, 0, 3'd2, 32'h0, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_rd !== 32'hCAFEF00D || last_resp !== 1'b0 || n_err_resp - n0 != 1 || cyc != 3) begin
      errors++;
      $display("FAIL out_of_range: got %h resp %0d errs %0d cyc %0d, required cafef00d 0 1 3",
               last_rd, last_resp, n_err_resp - n0, cyc);
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    cur = 1;
    push(32'h0, 1, 3'd2, 32'h12345678, 4'b0011);
    push(32'h4, 1, 3'd2, 32'h9ABCDEF0, 4'b0011);
    push(32'h0, 0, 3'd2, 32'h0, 4'b0011);
    push(32'h4, 0, 3'd2, 32'h0, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_rd !== 32'h9ABCDEF0 || cyc != 12) begin
      errors++; $display("FAIL wait_states: got %h cyc %0d, required 9abcdef0 12", last_rd, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] a;
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(255)) << 2;
      push(a, 1, 3'd2, $urandom, 4'b0011);
      push(a, 0, 3'd2, 32'h0, 4'b0011);
    end
    run(0, cyc);
    checks++;
    if (cyc != 16) begin errors++; $display("FAIL back_to_back_cycles: got %0d, required 16", cyc); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    cur = 1;
    push(32'h8, 1, 3'd2, 32'h11111111, 4'b0011);
    run(0, cyc);
    hsel_bus = 1'b1; htrans = 2'b10; haddr = 32'h8; hwrite = 1'b1; hsize = 3'd2; hprot = 4'b0011;
    @(posedge hclk); #1;
    hwdata = 32'h55;
    idle_bus();
    checks++;
    if (ho1 !== 1'b0) begin errors++; $display("FAIL mid_wait: hreadyout=%0d, required 0", ho1); end
    hreset = 1'b1;
    #1;
    checks++;
    if (ho1 !== 1'b1 || hr1 !== 1'b0 || rd1 !== '0) begin
      errors++; $display("FAIL mid_reset: %0d %0d %h, required 1 0 0", ho1, hr1, rd1);
    end
    @(posedge hclk);
    @(negedge hclk) hreset = 1'b0;
    push(32'h8, 0, 3'd2, 32'h0, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_rd !== 32'h11111111) begin errors++; $display("FAIL mid_reset_data: got %h, required 11111111", last_rd); end
  endtask

  task automatic test_prot();
    int cyc;
    cur = 0;
`ifdef AHB_SLV_PROT_EN
    push(32'h200, 1, 3'd2, 32'h0BAD0BAD, 4'b0001);
    run(0, cyc);
    checks++;
    if (last_resp !== 1'b1) begin errors++; $display("FAIL prot_user: hresp=%0d, required 1", last_resp); end
`endif
    push(32'h200, 1, 3'd2, 32'h600D600D, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_resp !== 1'b0) begin errors++; $display("FAIL prot_priv: hresp=%0d, required 0", last_resp); end
    push(32'h204, 1, 3'd2, 32'h5A5A5A5A, 4'b0000);
    push(32'h200, 0, 3'd2, 32'h0, 4'b0011);
    run(0, cyc);
    checks++;
    if (last_rd !== 32'h600D600D) begin errors++; $display("FAIL prot_read: got %h, required 600d600d", last_rd); end
  endtask

  task automatic test_random();
    int cyc, r;
    logic [2:0] s;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      cur = d;
      for (int i = 0; i < 150; i++) begin
        s = $urandom_range(9) == 0 ? 3'd3 : 3'($urandom_range(2));
        r = $urandom_range(9);
        a = ($urandom_range(1) == 1 ? 32'd512 : 32'd0) + 32'($urandom_range(63));
        if (r < 8) a = a & ~((32'd1 << s) - 32'd1);
        if (r == 9) a = 32'($urandom_range(4095, 1024));
        push(a, 1'($urandom_range(1)), s, $urandom, 4'($urandom));
      end
      run(25, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lane();
    test_error();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    test_prot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_lite_sram_slave_p.md
Name: ahb_lite_sram_slave_p

Overview:
Parametrised AHB-Lite SRAM slave, successor to the fixed-geometry ahb3liten slave used in the AHB bench. Width, depth and wait states are configurable. Adds byte/halfword lane writes, a two-cycle ERROR response (out-of-range, misaligned, oversized) and pipelined back-to-back transfers. Sits behind the AHB decoder as a single memory slave; the bench top instantiates it in place of the legacy DUT.

Parameters:
- ADDR_W, 32, haddr width
- DATA_W, 32, data bus width; legal values 32 or 64
- DEPTH, 256, number of DATA_W words; power of 2
- WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY transfer (0..15)

Ports:
- hclk  in  1  bus clock
- hreset  in  1  asynchronous active-high reset
- hsel  in  1  slave select
- haddr  in  ADDR_W  address-phase address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1 = write
- hsize  in  3  transfer size, log2 bytes
- hburst  in  3  burst type; informational only
- hprot  in  4  protection
- hwdata  in  DATA_W  write data, data phase
- hready  in  1  bus ready (previous transfer complete)
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_W  read data, data phase

Behaviour:
- Single clock hclk. Reset hreset is asynchronous and active-high.
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE. Memory array is not reset.
- Address phase is accepted when hsel & hready & htrans[1]. On acceptance, register addr, hwrite, hsize and the error flag.
- BUSY, IDLE, or hsel=0: no data phase is opened. The slave returns zero-wait OKAY.
- Derived constants: LSB = log2(DATA_W/8); word index = addr[LSB +: log2(DEPTH)].
- Error flag is set if any of:
  - hsize > LSB
  - addr not aligned to 2^hsize
  - haddr >= DEPTH*DATA_W/8
- FSM states:
  - IDLE: a good transfer is accepted → WAIT if WAIT_STATES>0, else DATA. A bad transfer is accepted → ERR1.
  - WAIT: hreadyout=0; counter counts down from WAIT_STATES-1. Go to DATA when the counter hits 0.
  - DATA: hreadyout=1, hresp=0.
    - Write: commit hwdata lanes at this clock edge.
    - Read: hrdata = mem[index] during this cycle.
    - Next state by the new address phase, if any: good → WAIT or DATA; bad → ERR1; none → IDLE.
  - ERR1: hreadyout=0, hresp=1. No memory write.
  - ERR2: hreadyout=1, hresp=1. The next address phase is sampled here with the same rules as DATA.
- Byte lanes: little-endian. Lane mask = ((1<<2^hsize)-1) << addr[LSB-1:0]. Only masked bytes are written.
- Reads return the full word. hrdata = 0 outside the DATA state.
- Write then read to the same address back-to-back: the read returns the new data, since the write commits before the read data phase.
- Zero-wait pipelining: a new NONSEQ/SEQ in every cycle gives one transfer per cycle.
- hburst is ignored. Bursts are handled as independent transfers; no boundary check.
- hreset asserted mid-transfer:
  - The transfer is aborted immediately.
  - A pending write is not committed.
  - Outputs return to reset values asynchronously.

Optional Feature:
- Macro: AHB_SLV_PROT_EN.
- Defined:
  - A non-privileged access (hprot[1]=0) to the upper half of memory (index MSB=1) raises the error flag. Response is the two-cycle ERROR; no write is performed.
  - A data-only fetch with hprot[0]=0 is unaffected.
- Undefined: hprot is ignored entirely; no extra logic is generated.

Test Plan:
- Defaults. NONSEQ write 0xDEADBEEF to 0x10, hsize=2; then NONSEQ read of 0x10 → hrdata=0xDEADBEEF, hresp=0, one data-phase cycle each.
- Byte write 0xAA to 0x13, hsize=0, hwdata=0xAA000000, over existing 0x11223344; then word read of 0x10 → 0xAA223344.
- Misaligned access: hsize=2 at 0x12 → ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1). A later read of 0x10 shows the memory unchanged.
- Out-of-range access at 0x400 (DEPTH=256) → two-cycle ERROR. The next NONSEQ read of 0x0, issued in ERR2, completes OKAY.
- WAIT_STATES=2. Back-to-back writes to 0x0 and 0x4, then reads of both → each data phase holds hreadyout=0 for exactly 2 cycles. Data is correct.
- Assert hreset in the WAIT state of a write of 0x55 to 0x8 (WAIT_STATES=2) → hreadyout=1 immediately. After reset release, a read of 0x8 returns its prior contents.
- With AHB_SLV_PROT_EN defined: write to 0x200 with hprot=4'b0001 → ERROR; the same write with hprot=4'b0011 → OKAY.
